conv_layer_input_controller: RTL

Sequencing FSM for the convolution layer's three-bank input row cache. It accepts start commands from the layer controller, fetches image rows from the pixel ROM and drives the cache's `current_state`, `read_index`, `preload_cycle` and `array_idx` inputs. It runs three operations (preload of rows 0–2, kernel shift over the three banks, single-row load) and returns a one-cycle completion acknowledge for each.

---
 rtl/conv_layer_input_controller.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/conv_layer_input_controller.sv
// conv_layer_input_controller: sequencing FSM for the conv layer's three-bank input row cache
// Fetches image rows from a 1-cycle-latency pixel ROM and steers the cache through
// preload (rows 0-2), kernel shift over the three banks, and single-row load.
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   cmd               0 idle, 1 preload start, 2 shift start, 3 load start
//   ack               one-cycle completion code (1 preload, 2 shift, 3 load fin)
//   current_state     cache state: 0 INIT 1 PRELOAD 2 ROW_0 3 ROW_1 4 ROW_2 5 BIAS 6 LOAD 7 IDLE
//   read_index        pixel slot index; 5'h1F is the prefetch slot (no cache write)
//   preload_cycle     preload row counter
//   array_idx         bank select; 3 selects the zero bus
//   shift_idx         shift position within a ROW state
//   rom_addr, rom_en  pixel ROM read port
//   image_done        every image row has been fetched
// Build option: define CONV_INPUT_CTRL_BIAS_EN to insert a one-cycle BIAS state after ROW_2.
module conv_layer_input_controller #(
  parameter int IMAGE_SIZE  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cmd,
  output logic [1:0]            ack,
  output logic [2:0]            current_state,
  output logic [4:0]            read_index,
  output logic [1:0]            preload_cycle,
  output logic [1:0]            array_idx,
  output logic [1:0]            shift_idx,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_en,
  output logic                  image_done
);
  localparam int RPW = $clog2(IMAGE_SIZE + 1);
  localparam logic [4:0] PREFETCH = 5'h1F;
  localparam logic [4:0] LAST_SLOT = 5'(IMAGE_SIZE - 1);
  localparam logic [4:0] END_SLOT = 5'(IMAGE_SIZE);
  localparam logic [1:0] LAST_SHIFT = 2'(KERNEL_SIZE - 1);
  // Command codes double as the matching completion codes on ack.
  localparam logic [1:0] OP_PRELOAD = 2'd1;
  localparam logic [1:0] OP_SHIFT = 2'd2;
  localparam logic [1:0] OP_LOAD = 2'd3;
  typedef enum logic [2:0] {
    S_INIT, S_PRELOAD, S_ROW_0, S_ROW_1, S_ROW_2, S_BIAS, S_LOAD, S_IDLE
  } state_t;
  state_t state_q, state_d;
  logic [1:0] ack_q, ack_d;
  logic [4:0] read_index_q, read_index_d;
  logic [1:0] preload_cycle_q, preload_cycle_d;
  logic [1:0] array_idx_q, array_idx_d;
  logic [1:0] shift_idx_q, shift_idx_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic rom_en_q, rom_en_d;
  logic [RPW-1:0] row_ptr_q, row_ptr_d, row_ptr_inc;
  logic image_done_q, image_done_d;
  logic preloaded_q, preloaded_d;
  logic armed_q, armed_d;
  logic [ADDR_WIDTH-1:0] row_base, fetch_addr;
  logic [4:0] next_slot;
  logic fetch_en;
  assign row_base = ADDR_WIDTH'(row_ptr_q) * ADDR_WIDTH'(IMAGE_SIZE);
  assign row_ptr_inc = (row_ptr_q == RPW'(IMAGE_SIZE)) ? row_ptr_q : row_ptr_q + 1'b1;
  assign next_slot = (read_index_q == PREFETCH) ? 5'd0 : read_index_q + 5'd1;
  // The ROM is read one slot ahead so pixel k's data lands during slot k;
  // the last slot of a row therefore issues no read.
  assign fetch_en = next_slot < LAST_SLOT;
  assign fetch_addr = row_base + ADDR_WIDTH'(next_slot) + ADDR_WIDTH'(1);
  always_comb begin
    state_d = state_q;
    ack_d = 2'd0;
    read_index_d = 5'd0;
    preload_cycle_d = 2'd0;
    array_idx_d = 2'd3;
    shift_idx_d = 2'd0;
    rom_addr_d = '0;
    rom_en_d = 1'b0;
    row_ptr_d = row_ptr_q;
    image_done_d = image_done_q;
    preloaded_d = preloaded_q;
    armed_d = armed_q;
    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (cmd == 2'd0) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          // Any accepted-or-dropped command disarms until cmd returns to 0.
          armed_d = 1'b0;
          if (cmd == OP_PRELOAD) begin
            state_d = S_PRELOAD;
            row_ptr_d = '0;
            preloaded_d = 1'b0;
            image_done_d = 1'b0;
            read_index_d = PREFETCH;
            rom_en_d = 1'b1;
          end else if (cmd == OP_SHIFT && preloaded_q) begin
            state_d = S_ROW_0;
            array_idx_d = 2'd0;
          end else if (cmd == OP_LOAD && preloaded_q && !image_done_q) begin
            state_d = S_LOAD;
            read_index_d = PREFETCH;
            rom_en_d = 1'b1;
            rom_addr_d = row_base;
          end
        end
      end
      S_PRELOAD: begin
        preload_cycle_d = preload_cycle_q;
        if (read_index_q == END_SLOT) begin
          // preload_cycle 3 marks the terminal slot of row 2 (no cache shift).
          if (preload_cycle_q == 2'd3) begin
            state_d = S_IDLE;
            preloaded_d = 1'b1;
            ack_d = OP_PRELOAD;
            preload_cycle_d = 2'd0;
          end else begin
            preload_cycle_d = preload_cycle_q + 2'd1;
            read_index_d = PREFETCH;
            rom_en_d = 1'b1;
            rom_addr_d = row_base;
          end
        end else if (read_index_q == LAST_SLOT) begin
          row_ptr_d = row_ptr_inc;
          read_index_d = END_SLOT;
          preload_cycle_d = (preload_cycle_q == 2'd2) ? 2'd3 : preload_cycle_q;
        end else begin
          read_index_d = next_slot;
          rom_en_d = fetch_en;
          rom_addr_d = fetch_en ? fetch_addr : '0;
        end
      end
      S_LOAD: begin
        if (read_index_q == LAST_SLOT) begin
          state_d = S_IDLE;
          ack_d = OP_LOAD;
          row_ptr_d = row_ptr_inc;
          image_done_d = row_ptr_inc == RPW'(IMAGE_SIZE);
        end else begin
          read_index_d = next_slot;
          rom_en_d = fetch_en;
          rom_addr_d = fetch_en ? fetch_addr : '0;
        end
      end
      S_ROW_0, S_ROW_1, S_ROW_2: begin
        array_idx_d = array_idx_q;
        shift_idx_d = shift_idx_q + 2'd1;
        if (shift_idx_q == LAST_SHIFT) begin
          shift_idx_d = 2'd0;
          if (state_q == S_ROW_0) begin
            state_d = S_ROW_1;
            array_idx_d = 2'd1;
          end else if (state_q == S_ROW_1) begin
            state_d = S_ROW_2;
            array_idx_d = 2'd2;
          end else begin
            array_idx_d = 2'd3;
`ifdef CONV_INPUT_CTRL_BIAS_EN
            state_d = S_BIAS;
`else
            state_d = S_IDLE;
            ack_d = OP_SHIFT;
`endif
          end
        end
      end
      S_BIAS: begin
        state_d = S_IDLE;
        ack_d = OP_SHIFT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ack_q <= 2'd0;
      read_index_q <= 5'd0;
      preload_cycle_q <= 2'd0;
      array_idx_q <= 2'd3;
      shift_idx_q <= 2'd0;
      rom_addr_q <= '0;
      rom_en_q <= 1'b0;
      row_ptr_q <= '0;
      image_done_q <= 1'b0;
      preloaded_q <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ack_q <= ack_d;
      read_index_q <= read_index_d;
      preload_cycle_q <= preload_cycle_d;
      array_idx_q <= array_idx_d;
      shift_idx_q <= shift_idx_d;
      rom_addr_q <= rom_addr_d;
      rom_en_q <= rom_en_d;
      row_ptr_q <= row_ptr_d;
      image_done_q <= image_done_d;
      preloaded_q <= preloaded_d;
      armed_q <= armed_d;
    end
  end
  assign current_state = state_q;
  assign ack = ack_q;
  assign read_index = read_index_q;
  assign preload_cycle = preload_cycle_q;
  assign array_idx = array_idx_q;
  assign shift_idx = shift_idx_q;
  assign rom_addr = rom_addr_q;
  assign rom_en = rom_en_q;
  assign image_done = image_done_q;
endmodule
